// File: rtl/uart_rx_packet_parser_pkg.sv
// Shared types and constants for the UART packet parser and its payload buffer.
package uart_rx_packet_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // One UART character is start + 8 data + stop bits.
  localparam int BYTE_TIME_BITS = 10;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: one synchronous write port, one combinational read port, contents not reset.
// Zero-latency read; no flow control of its own.
module uart_pkt_buf
  import uart_rx_packet_parser_pkg::*;
#(
  parameter int MAX_PAYLOAD = 16,
  parameter int ADDR_W      = addr_width(MAX_PAYLOAD)
) (
  input  logic              i_Clk,
  input  logic              i_We,
  input  logic [ADDR_W-1:0] i_Wr_Addr,
  input  logic [7:0]        i_Wr_Dat,
  input  logic [ADDR_W-1:0] i_Rd_Addr,
  output logic [7:0]        o_Rd_Dat
);

  logic [7:0] r_mem [MAX_PAYLOAD];

  always_ff @(posedge i_Clk) begin
    if (i_We) begin
      r_mem[i_Wr_Addr] <= i_Wr_Dat;
    end
  end

  assign o_Rd_Dat = r_mem[i_Rd_Addr];

endmodule

// File: rtl/uart_rx_packet_parser.sv
// Frames SYNC/LEN/payload/CSUM packets from a UART byte strobe; first payload byte is valid one cycle after CSUM.
// Payload output stalls on i_Byte_Ready; bytes arriving while the payload is being drained are dropped and flagged.
module uart_rx_packet_parser
  import uart_rx_packet_parser_pkg::*;
#(
  parameter int         CLOCKS_PER_BIT = 217,
  parameter int         MAX_PAYLOAD    = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_BYTES  = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_Byte,
  output logic       o_Byte_Valid,
  input  logic       i_Byte_Ready,
  output logic       o_Byte_Last,
  output logic       o_Err_Csum,
  output logic       o_Err_Len,
  output logic       o_Err_Timeout,
  output logic       o_Err_Overrun
);

  localparam int              IDX_W     = $clog2(MAX_PAYLOAD + 1);
  localparam int              ADDR_W    = addr_width(MAX_PAYLOAD);
  localparam int              TO_TERM   = TIMEOUT_BYTES * BYTE_TIME_BITS * CLOCKS_PER_BIT - 1;
  localparam int              TO_W      = $clog2(TO_TERM + 1);
  localparam logic [TO_W-1:0] TO_TERM_C = TO_W'(TO_TERM);
  localparam logic [7:0]      MAX_LEN   = 8'(MAX_PAYLOAD);

  state_t            r_state;
  logic [7:0]        r_sum;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [IDX_W-1:0]  r_last_idx;
  logic [TO_W-1:0]   r_to_cnt;

  logic              w_len_ok;
  logic              w_to_active;
  logic              w_to_fire;
  logic              w_xfer;
  logic              w_we;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [7:0]        w_rd_dat;

  assign w_len_ok    = (i_RX_Byte != 8'd0) && (i_RX_Byte <= MAX_LEN);
  assign w_to_active = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
  // A byte landing on the terminal count wins over the timeout.
  assign w_to_fire   = w_to_active && !i_RX_DV && (r_to_cnt == TO_TERM_C);
  assign w_xfer      = o_Byte_Valid && i_Byte_Ready;
  assign w_we        = (r_state == ST_PAYLOAD) && i_RX_DV;

  // In CSUM the first entry is prefetched; while draining, the entry after the one on o_Byte.
  assign w_rd_addr = (r_state == ST_DRAIN) ? (r_rd_idx[ADDR_W-1:0] + ADDR_W'(1)) : '0;

  uart_pkt_buf #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .ADDR_W      (ADDR_W)
  ) u_buf (
    .i_Clk     (i_Clk),
    .i_We      (w_we),
    .i_Wr_Addr (r_idx[ADDR_W-1:0]),
    .i_Wr_Dat  (i_RX_Byte),
    .i_Rd_Addr (w_rd_addr),
    .o_Rd_Dat  (w_rd_dat)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state       <= ST_IDLE;
      r_sum         <= '0;
      r_idx         <= '0;
      r_rd_idx      <= '0;
      r_last_idx    <= '0;
      r_to_cnt      <= '0;
      o_Byte        <= '0;
      o_Byte_Valid  <= 1'b0;
      o_Byte_Last   <= 1'b0;
      o_Err_Csum    <= 1'b0;
      o_Err_Len     <= 1'b0;
      o_Err_Timeout <= 1'b0;
      o_Err_Overrun <= 1'b0;
    end else begin
      o_Err_Csum    <= 1'b0;
      o_Err_Len     <= 1'b0;
      o_Err_Timeout <= 1'b0;
      o_Err_Overrun <= 1'b0;

      if (i_RX_DV || !w_to_active || w_to_fire) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
            r_state <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (i_RX_DV) begin
            if (w_len_ok) begin
              r_sum      <= i_RX_Byte;
              r_idx      <= '0;
              r_last_idx <= IDX_W'(i_RX_Byte - 8'd1);
              r_state    <= ST_PAYLOAD;
            end else begin
              o_Err_Len <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end else if (w_to_fire) begin
            o_Err_Timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        ST_PAYLOAD: begin
          if (i_RX_DV) begin
            r_sum <= r_sum + i_RX_Byte;
            r_idx <= r_idx + IDX_W'(1);
            if (r_idx == r_last_idx) begin
              r_state <= ST_CSUM;
            end
          end else if (w_to_fire) begin
            o_Err_Timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        ST_CSUM: begin
          if (i_RX_DV) begin
            if (i_RX_Byte == r_sum) begin
              r_rd_idx     <= '0;
              o_Byte       <= w_rd_dat;
              o_Byte_Last  <= (r_last_idx == '0);
              o_Byte_Valid <= 1'b1;
              r_state      <= ST_DRAIN;
            end else begin
              o_Err_Csum <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end else if (w_to_fire) begin
            o_Err_Timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (i_RX_DV) begin
            o_Err_Overrun <= 1'b1;
          end
          if (w_xfer) begin
            if (o_Byte_Last) begin
              o_Byte_Valid <= 1'b0;
              o_Byte_Last  <= 1'b0;
              o_Byte       <= '0;
              r_state      <= ST_IDLE;
            end else begin
              r_rd_idx    <= r_rd_idx + IDX_W'(1);
              o_Byte      <= w_rd_dat;
              o_Byte_Last <= ((r_rd_idx + IDX_W'(1)) == r_last_idx);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Self-checking bench for uart_rx_packet_parser: directed scenarios plus randomized packets against a packet-level model.
module tb_uart_rx_packet_parser;

  localparam int         MAXP     = 16;
  localparam logic [7:0] SYNC     = 8'hA5;
  localparam int         TO_CYC   = 4 * 10 * 217;

  typedef logic [7:0] bq_t[$];

  logic       i_Clk = 1'b0;
  logic       i_Rst_n;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic [7:0] o_Byte;
  logic       o_Byte_Valid;
  logic       i_Byte_Ready;
  logic       o_Byte_Last;
  logic       o_Err_Csum;
  logic       o_Err_Len;
  logic       o_Err_Timeout;
  logic       o_Err_Overrun;

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor state
  logic [8:0] got_q[$];
  int         got_cyc[$];
  int         cyc = 0;
  int         n_csum = 0, n_len = 0, n_to = 0, n_ovr = 0;
  int         multi_err = 0;
  int         stab_err = 0;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_byte;
  logic       hold_last;

  uart_rx_packet_parser #(
    .CLOCKS_PER_BIT (217),
    .MAX_PAYLOAD    (MAXP),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_BYTES  (4)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Rst_n       (i_Rst_n),
    .i_RX_DV       (i_RX_DV),
    .i_RX_Byte     (i_RX_Byte),
    .o_Byte        (o_Byte),
    .o_Byte_Valid  (o_Byte_Valid),
    .i_Byte_Ready  (i_Byte_Ready),
    .o_Byte_Last   (o_Byte_Last),
    .o_Err_Csum    (o_Err_Csum),
    .o_Err_Len     (o_Err_Len),
    .o_Err_Timeout (o_Err_Timeout),
    .o_Err_Overrun (o_Err_Overrun)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) begin
    cyc++;
    if (i_Rst_n) begin
      if (hold_pending && !(o_Byte_Valid && o_Byte == hold_byte && o_Byte_Last == hold_last))
        stab_err++;
      if (o_Byte_Valid && i_Byte_Ready) begin
        got_q.push_back({o_Byte_Last, o_Byte});
        got_cyc.push_back(cyc);
      end
      n_csum += int'(o_Err_Csum);
      n_len  += int'(o_Err_Len);
      n_to   += int'(o_Err_Timeout);
      n_ovr  += int'(o_Err_Overrun);
      if (int'(o_Err_Csum) + int'(o_Err_Len) + int'(o_Err_Timeout) + int'(o_Err_Overrun) > 1)
        multi_err++;
      hold_pending = o_Byte_Valid && !i_Byte_Ready;
      hold_byte    = o_Byte;
      hold_last    = o_Byte_Last;
    end else begin
      hold_pending = 1'b0;
    end
  end

  // All driving happens 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    tick(1);
    i_RX_DV   = 1'b0;
    tick(gap);
  endtask

  // Last byte of the sequence is sent with no trailing gap.
  task automatic send_seq(input bq_t seq, input int gap);
    foreach (seq[i]) send_byte(seq[i], (i == seq.size() - 1) ? 0 : gap);
  endtask

  task automatic test_reset;
    i_Rst_n = 1'b0; i_RX_DV = 1'b0; i_RX_Byte = 8'h00; i_Byte_Ready = 1'b1;
    tick(3);
    n_assert++;
    if ({o_Byte, o_Byte_Valid, o_Byte_Last} !== 10'b0) begin
      n_fail++; $display("FAIL reset_data: got %h/%b/%b required 00/0/0", o_Byte, o_Byte_Valid, o_Byte_Last);
    end
    n_assert++;
    if ({o_Err_Csum, o_Err_Len, o_Err_Timeout, o_Err_Overrun} !== 4'b0) begin
      n_fail++; $display("FAIL reset_errs: got %b required 0000", {o_Err_Csum, o_Err_Len, o_Err_Timeout, o_Err_Overrun});
    end
    i_Rst_n = 1'b1;
    tick(3);
    n_assert++;
    if (o_Byte_Valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_valid: got %b required 0", o_Byte_Valid);
    end
  endtask

  task automatic test_good_packet;
    int   b0 = got_q.size();
    int   e0 = n_csum + n_len + n_to + n_ovr;
    bq_t  exp = {8'h11, 8'h22, 8'h33};
    i_Byte_Ready = 1'b1;
    send_seq({SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 1);
    n_assert++;
    if (o_Byte_Valid !== 1'b1 || o_Byte !== 8'h11) begin
      n_fail++; $display("FAIL good_first_latency: got valid=%b byte=%h required valid=1 byte=11", o_Byte_Valid, o_Byte);
    end
    tick(8);
    n_assert++;
    if (got_q.size() - b0 != 3) begin
      n_fail++; $display("FAIL good_count: got %0d bytes required 3", got_q.size() - b0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_assert++;
        if (got_q[b0+i] !== {(i == 2), exp[i]}) begin
          n_fail++; $display("FAIL good_byte%0d: got %h required %h", i, got_q[b0+i], {(i == 2), exp[i]});
        end
      end
      n_assert++;
      if (got_cyc[b0+2] - got_cyc[b0] != 2) begin
        n_fail++; $display("FAIL good_consecutive: got span %0d required 2", got_cyc[b0+2] - got_cyc[b0]);
      end
    end
    n_assert++;
    if (n_csum + n_len + n_to + n_ovr - e0 != 0) begin
      n_fail++; $display("FAIL good_errs: got %0d pulses required 0", n_csum + n_len + n_to + n_ovr - e0);
    end
  endtask

  task automatic test_bad_csum;
    int b0 = got_q.size();
    int c0 = n_csum;
    send_seq({SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68}, 1);
    tick(6);
    n_assert++;
    if (n_csum - c0 != 1) begin
      n_fail++; $display("FAIL csum_pulse: got %0d pulses required 1", n_csum - c0);
    end
    n_assert++;
    if (got_q.size() != b0) begin
      n_fail++; $display("FAIL csum_no_output: got %0d bytes required 0", got_q.size() - b0);
    end
    send_seq({SYNC, 8'h01, 8'h5A, 8'h5B}, 2);
    tick(5);
    n_assert++;
    if (got_q.size() != b0 + 1 || got_q[b0] !== 9'h15A) begin
      n_fail++; $display("FAIL csum_recover: got %0d bytes last=%h required 1 byte 15a", got_q.size() - b0, got_q[$]);
    end
  endtask

  task automatic test_len_errors;
    int b0 = got_q.size();
    int l0 = n_len;
    int t0 = n_csum + n_to + n_ovr;
    send_seq({SYNC, 8'h00}, 1);
    tick(3);
    n_assert++;
    if (n_len - l0 != 1) begin
      n_fail++; $display("FAIL len_zero: got %0d pulses required 1", n_len - l0);
    end
    send_seq({SYNC, 8'h20}, 1);
    tick(3);
    n_assert++;
    if (n_len - l0 != 2) begin
      n_fail++; $display("FAIL len_over: got %0d pulses required 2", n_len - l0);
    end
    send_seq({8'h01, 8'h11, 8'h12, 8'h24}, 1);
    tick(5);
    n_assert++;
    if (got_q.size() != b0 || n_csum + n_to + n_ovr != t0 || n_len - l0 != 2) begin
      n_fail++; $display("FAIL len_idle_after: got %0d bytes %0d other errs required 0 0", got_q.size() - b0, n_csum + n_to + n_ovr - t0);
    end
  endtask

  task automatic test_timeout;
    int b0 = got_q.size();
    int t0 = n_to;
    send_seq({SYNC, 8'h02, 8'h11}, 3);
    tick(TO_CYC - 80);
    n_assert++;
    if (n_to != t0) begin
      n_fail++; $display("FAIL timeout_early: got %0d pulses required 0", n_to - t0);
    end
    tick(120);
    n_assert++;
    if (n_to - t0 != 1) begin
      n_fail++; $display("FAIL timeout_pulse: got %0d pulses required 1", n_to - t0);
    end
    send_seq({SYNC, 8'h01, 8'h7E, 8'h7F}, 2);
    tick(5);
    n_assert++;
    if (got_q.size() != b0 + 1 || got_q[b0] !== 9'h17E) begin
      n_fail++; $display("FAIL timeout_recover: got %0d bytes last=%h required 1 byte 17e", got_q.size() - b0, got_q[$]);
    end
  endtask

  task automatic test_backpressure_overrun;
    int b0 = got_q.size();
    int o0 = n_ovr;
    int s0 = stab_err;
    i_Byte_Ready = 1'b0;
    // Modular sum of 02, AB, CD is 7A.
    send_seq({SYNC, 8'h02, 8'hAB, 8'hCD, 8'h7A}, 2);
    tick(2000);
    send_byte(8'h55, 0);
    tick(3000);
    n_assert++;
    if (o_Byte_Valid !== 1'b1 || o_Byte !== 8'hAB || o_Byte_Last !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold: got v=%b b=%h l=%b required v=1 b=ab l=0", o_Byte_Valid, o_Byte, o_Byte_Last);
    end
    n_assert++;
    if (stab_err != s0) begin
      n_fail++; $display("FAIL bp_stable: got %0d unstable cycles required 0", stab_err - s0);
    end
    n_assert++;
    if (n_ovr - o0 != 1) begin
      n_fail++; $display("FAIL bp_overrun: got %0d pulses required 1", n_ovr - o0);
    end
    i_Byte_Ready = 1'b1;
    tick(6);
    n_assert++;
    if (got_q.size() - b0 != 2) begin
      n_fail++; $display("FAIL bp_count: got %0d bytes required 2", got_q.size() - b0);
    end else begin
      n_assert++;
      if (got_q[b0] !== 9'h0AB || got_q[b0+1] !== 9'h1CD) begin
        n_fail++; $display("FAIL bp_data: got %h %h required 0ab 1cd", got_q[b0], got_q[b0+1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int b0;
    int e0;
    send_seq({SYNC, 8'h04, 8'h01, 8'h02}, 1);
    i_Rst_n = 1'b0;
    #2;
    n_assert++;
    if ({o_Byte, o_Byte_Valid, o_Byte_Last, o_Err_Csum, o_Err_Len, o_Err_Timeout, o_Err_Overrun} !== 14'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h required 0", {o_Byte, o_Byte_Valid, o_Byte_Last});
    end
    tick(3);
    i_Rst_n = 1'b1;
    tick(2);
    b0 = got_q.size();
    e0 = n_csum + n_len + n_to + n_ovr;
    send_seq({SYNC, 8'h01, 8'hFF, 8'h00}, 1);
    tick(5);
    n_assert++;
    if (got_q.size() != b0 + 1 || got_q[b0] !== 9'h1FF) begin
      n_fail++; $display("FAIL rstmid_recover: got %0d bytes last=%h required 1 byte 1ff", got_q.size() - b0, got_q[$]);
    end
    n_assert++;
    if (n_csum + n_len + n_to + n_ovr != e0) begin
      n_fail++; $display("FAIL rstmid_errs: got %0d pulses required 0", n_csum + n_len + n_to + n_ovr - e0);
    end
    // Reset while a checked payload is waiting must drop valid at once.
    i_Byte_Ready = 1'b0;
    send_seq({SYNC, 8'h01, 8'h3C, 8'h3D}, 1);
    i_Rst_n = 1'b0;
    #1;
    n_assert++;
    if (o_Byte_Valid !== 1'b0) begin
      n_fail++; $display("FAIL rstdrain_valid: got %b required 0", o_Byte_Valid);
    end
    tick(2);
    i_Rst_n = 1'b1;
    i_Byte_Ready = 1'b1;
    tick(2);
  endtask

  task automatic test_random;
    int         b0 = got_q.size();
    int         c0 = n_csum, l0 = n_len, t0 = n_to, o0 = n_ovr;
    int         s0 = stab_err;
    int         m0 = multi_err;
    int         exp_csum = 0, exp_len = 0;
    logic [8:0] exp_q[$];
    for (int p = 0; p < 40; p++) begin
      int         kind = $urandom_range(0, 9);
      int         len;
      int         sum;
      logic [7:0] pl[$];
      logic [7:0] nb;
      repeat ($urandom_range(0, 2)) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == SYNC) nb = 8'h00;
        send_byte(nb, $urandom_range(0, 3));
      end
      if (kind == 0) len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAXP + 1, 255);
      else len = $urandom_range(1, MAXP);
      send_byte(SYNC, $urandom_range(0, 3));
      send_byte(8'(len), $urandom_range(0, 3));
      if (len == 0 || len > MAXP) begin
        exp_len++;
        tick(2);
      end else begin
        sum = len;
        for (int i = 0; i < len; i++) begin
          pl.push_back(8'($urandom_range(0, 255)));
          sum += pl[i];
          send_byte(pl[i], $urandom_range(0, 3));
        end
        if (kind == 1) begin
          send_byte(8'((sum + $urandom_range(1, 255)) % 256), 0);
          exp_csum++;
        end else begin
          send_byte(8'(sum % 256), 0);
          for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), pl[i]});
        end
        for (int c = 0; c < 400 && o_Byte_Valid; c++) begin
          i_Byte_Ready = ($urandom_range(0, 1) == 1);
          tick(1);
        end
        i_Byte_Ready = 1'b1;
        n_assert++;
        if (o_Byte_Valid !== 1'b0) begin
          n_fail++; $display("FAIL rand_drain_done pkt%0d: valid=%b required 0 within budget", p, o_Byte_Valid);
        end
        tick(1);
      end
    end
    tick(4);
    n_assert++;
    if (got_q.size() - b0 != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d bytes required %0d", got_q.size() - b0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_assert++;
        if (got_q[b0+i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_byte%0d: got %h required %h", i, got_q[b0+i], exp_q[i]);
        end
      end
    end
    n_assert++;
    if (n_csum - c0 != exp_csum || n_len - l0 != exp_len) begin
      n_fail++; $display("FAIL rand_errs: got csum=%0d len=%0d required csum=%0d len=%0d", n_csum - c0, n_len - l0, exp_csum, exp_len);
    end
    n_assert++;
    if (n_to != t0 || n_ovr != o0) begin
      n_fail++; $display("FAIL rand_no_to_ovr: got to=%0d ovr=%0d required 0 0", n_to - t0, n_ovr - o0);
    end
    n_assert++;
    if (stab_err != s0 || multi_err != m0) begin
      n_fail++; $display("FAIL rand_protocol: got unstable=%0d multi_err=%0d required 0 0", stab_err - s0, multi_err - m0);
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_csum();
    test_len_errors();
    test_timeout();
    test_backpressure_overrun();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
